// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro: DMEM_LOAD_EXT_EN (load lane select + extension in the responder).
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Byte lanes touched by a store of the given size at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Right-aligned store data replicated across all lanes; the mask picks the live ones.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SIZE_BYTE: return {4{wd[7:0]}};
            SIZE_HALF: return {2{wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

    // Pull the addressed byte/half down to bit 0 and extend it; words pass through.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SIZE_BYTE: return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// DEPTH_WORDS x 32 synchronous RAM with per-byte write enable; contents are never reset.
module dmem_ram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Write enabled lanes and capture the pre-write word in the same access.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY, error flagging.
// Optional feature macro: DMEM_LOAD_EXT_EN (byte/half extraction and extension of loads).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_we, r_uns;
    logic [1:0]    r_size;
    logic [31:0]   r_addr, r_wdata;

    logic          w_accept, w_commit, w_err;
    logic          w_cur_we;
    logic [1:0]    w_cur_size;
    logic [31:0]   w_cur_addr, w_cur_wdata, w_word_idx;
    logic [31:0]   w_ram_q, w_load;

    assign w_accept = i_req_valid && (r_state == ST_IDLE);

    // With LATENCY==1 the commit edge is the accept edge, so the RAM must see the live request.
    assign w_cur_we    = (r_state == ST_IDLE) ? i_req_we    : r_we;
    assign w_cur_size  = (r_state == ST_IDLE) ? i_req_size  : r_size;
    assign w_cur_addr  = (r_state == ST_IDLE) ? i_req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? i_req_wdata : r_wdata;

    assign w_word_idx = {2'b00, w_cur_addr[31:2]};
    assign w_err = (w_cur_size == 2'b11)
                || ((w_cur_size == SIZE_HALF) && w_cur_addr[0])
                || ((w_cur_size == SIZE_WORD) && (w_cur_addr[1:0] != 2'b00))
                || (w_word_idx >= 32'(DEPTH_WORDS));

    // State and countdown registers; async reset abandons any in-flight request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, countdown and the single commit strobe into the RAM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_RESP: begin
                if (i_resp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request fields captured at accept and held for the whole transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= i_req_we;
            r_uns   <= i_req_unsigned;
            r_size  <= i_req_size;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end
    end

    dmem_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (w_commit && !w_err),
        .i_be    (w_cur_we ? lane_mask(w_cur_size, w_cur_addr[1:0]) : 4'b0000),
        .i_addr  (w_cur_addr[AW+1:2]),
        .i_wdata (store_data(w_cur_size, w_cur_wdata)),
        .o_rdata (w_ram_q)
    );

`ifdef DMEM_LOAD_EXT_EN
    assign w_load = load_extract(w_ram_q, r_size, r_addr[1:0], r_uns);
`else
    // Full aligned word; the MEM stage does lane select and extension.
    assign w_load = w_ram_q;
`endif

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_resp_err   = (r_state == ST_RESP) && w_err;
    assign o_resp_rdata = ((r_state == ST_RESP) && !r_we && !w_err) ? w_load : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// checked against a word-array model of the memory.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int MW    = 32;   // modelled words: byte addresses 0x00..0x7F

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [MW];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_rdata   (resp_rdata),
        .o_resp_err     (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: error rules, lane writes and load extraction from plain arithmetic.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int wi, k;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        wi  = int'(a / 4);
        k   = int'(a % 4);
        err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && k != 0)
           || ((a / 4) >= DEPTH);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                if (sz == 2'd0)      mem[wi][8*k +: 8]  = wd[7:0];
                else if (sz == 2'd1) mem[wi][8*k +: 16] = wd[15:0];
                else                 mem[wi]            = wd;
            end else begin
                w = mem[wi];
`ifdef DMEM_LOAD_EXT_EN
                b = w[8*k +: 8];
                h = w[8*k +: 16];
                if (sz == 2'd0)      rd = uns ? 32'(b) : 32'($signed(b));
                else if (sz == 2'd1) rd = uns ? 32'(h) : 32'($signed(h));
                else                 rd = w;
`else
                b = 8'h0; h = 16'h0;
                rd = w;
`endif
            end
        end
    endtask

    // One full transaction: present, accept, count latency, hold RESP for `hold` cycles, handshake.
    task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [31:0] erd, rd0;
        logic        eerr;
        int          n;
        model(we, sz, uns, a, wd, erd, eerr);
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; resp_ready = 1'b0;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 10);
        chk({tag, ".latency"}, 32'(n), 32'(LAT));
        chk({tag, ".rdata"}, resp_rdata, erd);
        chk({tag, ".err"}, 32'(resp_err), 32'(eerr));
        rd0 = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, resp_rdata, rd0);
            chk({tag, ".hold_busy"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        // 1: reset with a pending request
        rst_n = 1'b0; req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(resp_valid), 32'd0);
        chk("rst.err",   32'(resp_err),   32'd0);
        chk("rst.rdata", resp_rdata,      32'd0);
        rst_n = 1'b1; req_valid = 1'b0;
        #1 chk("rst.ready", 32'(req_ready), 32'd1);

        // Give every modelled word a known value
        for (int w = 0; w < MW; w++) xact("init", 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0);

        // 2: word store/load
        xact("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        xact("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        chk("w10.model", mem[4], 32'hDEADBEEF);

        // 3: byte store and extending loads
        xact("st_b11",  1'b1, 2'd0, 1'b0, 32'h11, 32'h0000007F, 0);
        xact("ld_w10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        chk("b11.model", mem[4], 32'hDEAD7FEF);
        xact("ld_b13s", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        xact("ld_b13u", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        xact("st_h12",  1'b1, 2'd1, 1'b0, 32'h12, 32'h0000A5C3, 0);
        xact("ld_h12s", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
        xact("ld_h10u", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0);

        // 4: error cases leave RAM untouched
        xact("err_h21",  1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFFFFFF, 0);
        xact("err_w22",  1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 0);
        xact("err_sz3",  1'b1, 2'd3, 1'b0, 32'h24, 32'hFFFFFFFF, 0);
        xact("err_oor",  1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'hFFFFFFFF, 0);
        xact("err_ldh",  1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0);
        xact("ld_w20",   1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
        xact("ld_w24",   1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 0);

        // 5: backpressure in RESP
        xact("bp_ld10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        xact("bp_next", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);

        // 6: reset during WAIT of a store drops it
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h1234; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst.wait_valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b0;
        #1 chk("midrst.valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst.no_resp", 32'(resp_valid), 32'd0);
        end
        xact("midrst.ld40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);

        // Randomized traffic over the modelled window plus occasional out-of-range hits
        for (int t = 0; t < 80; t++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 1023))
                                              : 32'($urandom_range(0, 4 * MW - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            xact("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                 $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
